// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter: two per-source FIFOs feed a round-robin arbiter that drives
// the single SIMD register-file write port through registered strobes.
module regfile_wb_arbiter #(
  parameter int registerSize  = 32,
  parameter int vectorSize    = 4,
  parameter int selectionBits = 2,
  parameter int fifoDepth     = 2
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                wbValid0,
  output logic                                wbReady0,
  input  logic                                wbIsVec0,
  input  logic [selectionBits-1:0]            wbReg0,
  input  logic [vectorSize*registerSize-1:0]  wbData0,
  input  logic                                wbValid1,
  output logic                                wbReady1,
  input  logic                                wbIsVec1,
  input  logic [selectionBits-1:0]            wbReg1,
  input  logic [vectorSize*registerSize-1:0]  wbData1,
  output logic                                regWrEnSc,
  output logic                                regWrEnVec,
  output logic [selectionBits-1:0]            regToWrite,
  output logic [vectorSize*registerSize-1:0]  dataIn,
  output logic                                busy
);

  localparam int unsigned DW = vectorSize * registerSize;
  localparam int unsigned PW = $clog2(fifoDepth);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(fifoDepth);

  typedef struct packed {
    logic                     is_vec;
    logic [selectionBits-1:0] dst;
    logic [DW-1:0]            data;
  } entry_t;

  entry_t          mem [2][fifoDepth];
  entry_t          in_entry [2];
  entry_t          head;
  logic            in_valid [2];
  logic            ready [2];
  logic            push [2];
  logic            pop [2];
  logic            not_empty [2];
  logic [PW-1:0]   wr_ptr [2];
  logic [PW-1:0]   rd_ptr [2];
  logic [CW-1:0]   count [2];
  logic            last_grant;
  logic            grant_valid;
  logic            grant_sel;

  always_comb begin
    in_valid[0] = wbValid0;
    in_valid[1] = wbValid1;
    in_entry[0] = '{is_vec: wbIsVec0, dst: wbReg0, data: wbData0};
    in_entry[1] = '{is_vec: wbIsVec1, dst: wbReg1, data: wbData1};
  end

  // Ready depends only on registered count, never on this cycle's pop.
  always_comb begin
    for (int unsigned i = 0; i < 2; i++) begin
      ready[i]     = (count[i] != FULL) && !reset;
      push[i]      = in_valid[i] && ready[i];
      not_empty[i] = (count[i] != '0);
    end
  end

  always_comb begin
    grant_valid = not_empty[0] || not_empty[1];
    grant_sel   = 1'b0;
    if (not_empty[0] && not_empty[1])
      grant_sel = ~last_grant;
    else if (not_empty[1])
      grant_sel = 1'b1;
    pop[0] = grant_valid && !grant_sel;
    pop[1] = grant_valid && grant_sel;
    head   = mem[grant_sel][rd_ptr[grant_sel]];
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < 2; i++) begin
      if (push[i])
        mem[i][wr_ptr[i]] <= in_entry[i];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < 2; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        count[i]  <= '0;
      end
      last_grant <= 1'b1;
      regWrEnSc  <= 1'b0;
      regWrEnVec <= 1'b0;
      regToWrite <= '0;
      dataIn     <= '0;
    end else begin
      // Pointers wrap naturally since fifoDepth is a power of two.
      for (int unsigned i = 0; i < 2; i++) begin
        if (push[i])
          wr_ptr[i] <= wr_ptr[i] + 1'b1;
        if (pop[i])
          rd_ptr[i] <= rd_ptr[i] + 1'b1;
        if (push[i] && !pop[i])
          count[i] <= count[i] + 1'b1;
        else if (!push[i] && pop[i])
          count[i] <= count[i] - 1'b1;
      end
      if (grant_valid) begin
        last_grant <= grant_sel;
        regWrEnVec <= head.is_vec;
        regWrEnSc  <= !head.is_vec;
        regToWrite <= head.dst;
        dataIn     <= head.data;
      end else begin
        regWrEnVec <= 1'b0;
        regWrEnSc  <= 1'b0;
      end
    end
  end

  assign wbReady0 = ready[0];
  assign wbReady1 = ready[1];
  assign busy     = not_empty[0] || not_empty[1] || regWrEnSc || regWrEnVec;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: reset, latency, tie-break, backpressure,
// wrap-around and mid-operation reset, checked against hand-derived write orders.
module tb_regfile_wb_arbiter;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         wbValid0 = 1'b0, wbIsVec0 = 1'b0;
  logic         wbValid1 = 1'b0, wbIsVec1 = 1'b0;
  logic         wbReady0, wbReady1;
  logic [1:0]   wbReg0 = '0, wbReg1 = '0;
  logic [127:0] wbData0 = '0, wbData1 = '0;
  logic         regWrEnSc, regWrEnVec, busy;
  logic [1:0]   regToWrite;
  logic [127:0] dataIn;

  int n_assert = 0;
  int n_fail   = 0;

  logic [127:0] cap_data [32];
  logic         cap_vec [32];
  logic         cap_sc [32];
  logic [1:0]   cap_reg [32];
  int           cap_cyc [32];
  int           cap_n;
  bit           saw_r1_low;
  bit           vec_alt;
  logic [7:0]   tag0;
  logic [1:0]   r1tab [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

  always #5 clk = ~clk;

  regfile_wb_arbiter #(
    .registerSize (32),
    .vectorSize   (4),
    .selectionBits(2),
    .fifoDepth    (2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .wbValid0  (wbValid0),
    .wbReady0  (wbReady0),
    .wbIsVec0  (wbIsVec0),
    .wbReg0    (wbReg0),
    .wbData0   (wbData0),
    .wbValid1  (wbValid1),
    .wbReady1  (wbReady1),
    .wbIsVec1  (wbIsVec1),
    .wbReg1    (wbReg1),
    .wbData1   (wbData1),
    .regWrEnSc (regWrEnSc),
    .regWrEnVec(regWrEnVec),
    .regToWrite(regToWrite),
    .dataIn    (dataIn),
    .busy      (busy)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] pay(input logic [7:0] tag, input int k);
    return {32'(k), 32'h0, 32'hCAFE_0000, tag, 24'(k)};
  endfunction

  // Streams n0/n1 requests honouring ready and records every write strobe.
  task automatic run_stream(input int n0, input int n1, input int ncyc);
    int i0, i1;
    bit a0, a1;
    i0 = 0; i1 = 0; cap_n = 0; saw_r1_low = 0;
    for (int c = 0; c < ncyc; c++) begin
      wbValid0 = (i0 < n0);
      wbIsVec0 = vec_alt ? i0[0] : 1'b1;
      wbReg0   = 2'(i0);
      wbData0  = pay(tag0, i0);
      wbValid1 = (i1 < n1);
      wbIsVec1 = 1'b0;
      wbReg1   = r1tab[i1 % 5];
      wbData1  = pay(8'h20, i1);
      a0 = wbValid0 && wbReady0;
      a1 = wbValid1 && wbReady1;
      step();
      if (a0) i0++;
      if (a1) i1++;
      if (!wbReady1) saw_r1_low = 1;
      chk("both_enables", 128'(regWrEnSc && regWrEnVec), 128'd0);
      if (regWrEnSc || regWrEnVec) begin
        if (cap_n < 32) begin
          cap_data[cap_n] = dataIn;
          cap_vec[cap_n]  = regWrEnVec;
          cap_sc[cap_n]   = regWrEnSc;
          cap_reg[cap_n]  = regToWrite;
          cap_cyc[cap_n]  = c;
        end
        cap_n++;
      end
    end
    wbValid0 = 1'b0;
    wbValid1 = 1'b0;
  endtask

  task automatic expect_write(input int idx, input bit src, input int k);
    logic         ev;
    logic [1:0]   er;
    logic [127:0] ed;
    if (src == 1'b0) begin
      ev = vec_alt ? k[0] : 1'b1;
      er = 2'(k);
      ed = pay(tag0, k);
    end else begin
      ev = 1'b0;
      er = r1tab[k];
      ed = pay(8'h20, k);
    end
    chk("wr_present", 128'(idx < cap_n), 128'd1);
    if (idx < cap_n && idx < 32) begin
      chk("wr_vec", 128'(cap_vec[idx]), 128'(ev));
      chk("wr_sc", 128'(cap_sc[idx]), 128'(!ev));
      chk("wr_reg", 128'(cap_reg[idx]), 128'(er));
      chk("wr_data", cap_data[idx], ed);
    end
  endtask

  initial begin
    int bp_src [11];
    int bp_k [11];
    bp_src = '{1, 0, 1, 0, 1, 0, 1, 0, 1, 0, 0};
    bp_k   = '{0, 0, 1, 1, 2, 2, 3, 3, 4, 4, 5};
    vec_alt = 1'b0;
    tag0 = 8'h10;

    // Reset and idle
    #1 reset = 1'b1;
    #1;
    chk("rst_sc", 128'(regWrEnSc), 128'd0);
    chk("rst_vec", 128'(regWrEnVec), 128'd0);
    chk("rst_ready0", 128'(wbReady0), 128'd0);
    chk("rst_ready1", 128'(wbReady1), 128'd0);
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_data", dataIn, 128'd0);
    step();
    step();
    #2 reset = 1'b0;
    step();
    chk("idle_ready0", 128'(wbReady0), 128'd1);
    chk("idle_ready1", 128'(wbReady1), 128'd1);
    chk("idle_busy", 128'(busy), 128'd0);
    chk("idle_en", 128'({regWrEnSc, regWrEnVec}), 128'd0);
    chk("idle_reg", 128'(regToWrite), 128'd0);
    chk("idle_data", dataIn, 128'd0);

    // Simultaneous requests: source 0 wins the first tie after reset
    wbValid0 = 1'b1; wbIsVec0 = 1'b1; wbReg0 = 2'd1;
    wbData0 = {32'd4, 32'd3, 32'd2, 32'd1};
    wbValid1 = 1'b1; wbIsVec1 = 1'b0; wbReg1 = 2'd3; wbData1 = 128'h55;
    step();
    wbValid0 = 1'b0; wbValid1 = 1'b0;
    chk("sim_lat_en", 128'({regWrEnSc, regWrEnVec}), 128'd0);
    chk("sim_lat_busy", 128'(busy), 128'd1);
    step();
    chk("sim1_vec", 128'(regWrEnVec), 128'd1);
    chk("sim1_sc", 128'(regWrEnSc), 128'd0);
    chk("sim1_reg", 128'(regToWrite), 128'd1);
    chk("sim1_data", dataIn, {32'd4, 32'd3, 32'd2, 32'd1});
    chk("sim1_busy", 128'(busy), 128'd1);
    step();
    chk("sim2_sc", 128'(regWrEnSc), 128'd1);
    chk("sim2_vec", 128'(regWrEnVec), 128'd0);
    chk("sim2_reg", 128'(regToWrite), 128'd3);
    chk("sim2_data", dataIn, 128'h55);
    chk("sim2_busy", 128'(busy), 128'd1);
    step();
    chk("sim_end_en", 128'({regWrEnSc, regWrEnVec}), 128'd0);
    chk("sim_end_busy", 128'(busy), 128'd0);

    // Single scalar write latency
    wbValid0 = 1'b1; wbIsVec0 = 1'b0; wbReg0 = 2'd2; wbData0 = 128'hAB;
    step();
    wbValid0 = 1'b0;
    chk("sc_lat", 128'(regWrEnSc), 128'd0);
    step();
    chk("sc_en", 128'(regWrEnSc), 128'd1);
    chk("sc_vec", 128'(regWrEnVec), 128'd0);
    chk("sc_reg", 128'(regToWrite), 128'd2);
    chk("sc_data", dataIn, 128'hAB);
    step();
    chk("sc_once", 128'(regWrEnSc), 128'd0);
    chk("sc_hold_reg", 128'(regToWrite), 128'd2);
    chk("sc_hold_data", dataIn, 128'hAB);
    chk("sc_busy", 128'(busy), 128'd0);

    // Backpressure with alternation; lastGrant is 0 here so source 1 goes first
    vec_alt = 1'b0; tag0 = 8'h10;
    run_stream(6, 5, 20);
    chk("bp_count", 128'(cap_n), 128'd11);
    chk("bp_ready1_low", 128'(saw_r1_low), 128'd1);
    for (int i = 0; i < 11; i++) expect_write(i, bp_src[i] != 0, bp_k[i]);
    chk("bp_busy", 128'(busy), 128'd0);

    // Wrap-around: source 0 alone
    vec_alt = 1'b1; tag0 = 8'h30;
    run_stream(6, 0, 12);
    chk("wrap_count", 128'(cap_n), 128'd6);
    for (int i = 0; i < 6; i++) begin
      expect_write(i, 1'b0, i);
      if (i < cap_n) chk("wrap_consec", 128'(cap_cyc[i] - cap_cyc[0]), 128'(i));
    end
    chk("wrap_busy", 128'(busy), 128'd0);

    // Reset mid-operation
    vec_alt = 1'b0; tag0 = 8'h40;
    wbValid0 = 1'b1; wbIsVec0 = 1'b1; wbReg0 = 2'd0; wbData0 = pay(8'h40, 0);
    wbValid1 = 1'b1; wbIsVec1 = 1'b0; wbReg1 = 2'd1; wbData1 = pay(8'h20, 0);
    step();
    step();
    wbValid0 = 1'b0; wbValid1 = 1'b0;
    chk("pre_rst_busy", 128'(busy), 128'd1);
    chk("pre_rst_sc", 128'(regWrEnSc), 128'd1);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_sc", 128'(regWrEnSc), 128'd0);
    chk("mid_rst_vec", 128'(regWrEnVec), 128'd0);
    chk("mid_rst_reg", 128'(regToWrite), 128'd0);
    chk("mid_rst_data", dataIn, 128'd0);
    chk("mid_rst_busy", 128'(busy), 128'd0);
    chk("mid_rst_ready0", 128'(wbReady0), 128'd0);
    chk("mid_rst_ready1", 128'(wbReady1), 128'd0);
    step();
    #2 reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("post_rst_en", 128'({regWrEnSc, regWrEnVec}), 128'd0);
      chk("post_rst_busy", 128'(busy), 128'd0);
    end

    // Tie after reset again favours source 0
    vec_alt = 1'b0; tag0 = 8'h50;
    run_stream(1, 1, 6);
    chk("tie_count", 128'(cap_n), 128'd2);
    expect_write(0, 1'b0, 0);
    expect_write(1, 1'b1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
